// File: rtl/mult_pkg.sv
// mult_pkg: constants shared by the signed add-shift multiplier datapath.
//   DATA_W : operand width of A, B and the switch operand.
package mult_pkg;

   localparam int DATA_W = 8;

endpackage : mult_pkg

// File: rtl/multiplier_datapath_add_sub_9.sv
// add_sub_9: combinational (W+1)-bit ripple adder/subtractor.
//   A       in  W    accumulator operand (sign-extended internally)
//   S       in  W    switch operand (sign-extended internally)
//   Sub_Add in  1    1 = A - S, 0 = A + S
//   Sum     out W+1  result modulo 2^(W+1); Sum[W] is the extended sign
import mult_pkg::*;

module add_sub_9 #(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] S,
   input  logic         Sub_Add,
   output logic [W:0]   Sum
);

   logic [W:0] a_ext_s;
   logic [W:0] s_inv_s;
   logic       carry_s;

   // Subtraction is A + ~S + 1: invert the extended operand and use Sub_Add as carry-in.
   assign a_ext_s = {A[W-1], A};
   assign s_inv_s = {S[W-1], S} ^ {(W+1){Sub_Add}};

   // Ripple-carry chain over the W+1 extended bits; the final carry-out is discarded.
   always_comb begin
      carry_s = Sub_Add;
      Sum     = {(W+1){1'b0}};
      for (int i = 0; i <= W; i++) begin
         Sum[i]  = a_ext_s[i] ^ s_inv_s[i] ^ carry_s;
         carry_s = (a_ext_s[i] & s_inv_s[i]) | (a_ext_s[i] & carry_s) | (s_inv_s[i] & carry_s);
      end
   end

endmodule : add_sub_9

// File: rtl/multiplier_datapath.sv
// multiplier_datapath: register/arithmetic datapath of the 8-bit signed
// add-shift multiplier. Holds accumulator A, multiplier B and sign bit X.
//   Clk                      in   rising-edge clock
//   Reset                    in   asynchronous active-high reset
//   SW                       in   W   switch operand (B load source, adder operand S)
//   ClearA/LoadA/ShiftA      in   A strobes (priority clear > load > shift)
//   ClearB/LoadB/ShiftB      in   B strobes (priority clear > load > shift)
//   ClearX/LoadX/ShiftX      in   X strobes (priority clear > load > shift)
//   Sub_Add                  in   1 = A - SW, 0 = A + SW
//   Aval / Bval              out  W   current A / B
//   X                        out  current sign-extension bit
//   M                        out  B[0], returned to the control FSM
import mult_pkg::*;

module multiplier_datapath #(
   parameter int W = DATA_W
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [W-1:0] SW,
   input  logic         ClearA,
   input  logic         LoadA,
   input  logic         ShiftA,
   input  logic         ClearB,
   input  logic         LoadB,
   input  logic         ShiftB,
   input  logic         ClearX,
   input  logic         LoadX,
   input  logic         ShiftX,
   input  logic         Sub_Add,
   output logic [W-1:0] Aval,
   output logic [W-1:0] Bval,
   output logic         X,
   output logic         M
);

   logic [W-1:0] a_r;
   logic [W-1:0] b_r;
   logic         x_r;
   logic [W:0]   sum_s;

   add_sub_9 #(.W(W)) u_add_sub (
      .A       (a_r),
      .S       (SW),
      .Sub_Add (Sub_Add),
      .Sum     (sum_s)
   );

   // Accumulator: shift fills from X so the partial product stays sign-correct.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         a_r <= {W{1'b0}};
      end else if (ClearA) begin
         a_r <= {W{1'b0}};
      end else if (LoadA) begin
         a_r <= sum_s[W-1:0];
      end else if (ShiftA) begin
         a_r <= {x_r, a_r[W-1:1]};
      end else begin
         a_r <= a_r;
      end
   end

   // Multiplier: shift takes the pre-edge A[0], never the new sum, even when LoadA fires too.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         b_r <= {W{1'b0}};
      end else if (ClearB) begin
         b_r <= {W{1'b0}};
      end else if (LoadB) begin
         b_r <= SW;
      end else if (ShiftB) begin
         b_r <= {a_r[0], b_r[W-1:1]};
      end else begin
         b_r <= b_r;
      end
   end

   // Sign bit: load captures the extended adder sign; shift keeps it so the sign is replicated.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         x_r <= 1'b0;
      end else if (ClearX) begin
         x_r <= 1'b0;
      end else if (LoadX) begin
         x_r <= sum_s[W];
      end else if (ShiftX) begin
         x_r <= x_r;
      end else begin
         x_r <= x_r;
      end
   end

   assign Aval = a_r;
   assign Bval = b_r;
   assign X    = x_r;
   assign M    = b_r[0];

endmodule : multiplier_datapath

// File: tb/tb_multiplier_datapath.sv
// tb_multiplier_datapath: directed self-checking bench for multiplier_datapath.
module tb_multiplier_datapath;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] SW;
   logic       ClearA, LoadA, ShiftA;
   logic       ClearB, LoadB, ShiftB;
   logic       ClearX, LoadX, ShiftX;
   logic       Sub_Add;
   logic [7:0] Aval, Bval;
   logic       X, M;

   int assert_count = 0;
   int fail_count   = 0;

   multiplier_datapath dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .SW      (SW),
      .ClearA  (ClearA),
      .LoadA   (LoadA),
      .ShiftA  (ShiftA),
      .ClearB  (ClearB),
      .LoadB   (LoadB),
      .ShiftB  (ShiftB),
      .ClearX  (ClearX),
      .LoadX   (LoadX),
      .ShiftX  (ShiftX),
      .Sub_Add (Sub_Add),
      .Aval    (Aval),
      .Bval    (Bval),
      .X       (X),
      .M       (M)
   );

   always #5 Clk = ~Clk;

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      assert_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_strobes();
      ClearA = 1'b0; LoadA = 1'b0; ShiftA = 1'b0;
      ClearB = 1'b0; LoadB = 1'b0; ShiftB = 1'b0;
      ClearX = 1'b0; LoadX = 1'b0; ShiftX = 1'b0;
      Sub_Add = 1'b0;
   endtask

   // One clock edge with the currently driven strobes, then release them 1 time unit after it.
   task automatic tick();
      @(posedge Clk);
      #1;
      clear_strobes();
   endtask

   // Scripted FSM: load B, then 8 steps of (add/sub if M) + shift.
   task automatic run_mult(input logic [7:0] a_op, input logic [7:0] b_op,
                           input logic [15:0] exp, input string tag);
      SW = b_op; ClearA = 1'b1; ClearX = 1'b1; LoadB = 1'b1;
      tick();
      SW = a_op;
      for (int i = 0; i < 8; i++) begin
         if (M) begin
            LoadA = 1'b1; LoadX = 1'b1; Sub_Add = (i == 7);
            tick();
         end
         ShiftA = 1'b1; ShiftB = 1'b1; ShiftX = 1'b1;
         tick();
      end
      check_val(tag, {Aval, Bval}, exp);
   endtask

   initial begin
      clear_strobes();
      SW = 8'h00;
      Reset = 1'b1;
      #2;
      check_val("rst_A", {8'h00, Aval}, 16'h0000);
      check_val("rst_B", {8'h00, Bval}, 16'h0000);
      check_val("rst_X", {15'h0000, X}, 16'h0000);
      check_val("rst_M", {15'h0000, M}, 16'h0000);
      @(negedge Clk);
      Reset = 1'b0;

      // Build A=0x5A, B=0x33, X=1, then reset between edges.
      SW = 8'h33; LoadB = 1'b1;
      tick();
      SW = 8'h5A; LoadA = 1'b1;
      tick();
      SW = 8'h7F; Sub_Add = 1'b1; LoadX = 1'b1;     // 0x5A - 0x7F < 0 -> X=1
      tick();
      check_val("pre_A", {8'h00, Aval}, 16'h005A);
      check_val("pre_B", {8'h00, Bval}, 16'h0033);
      check_val("pre_X", {15'h0000, X}, 16'h0001);
      Reset = 1'b1;
      #1;
      check_val("arst_A", {8'h00, Aval}, 16'h0000);
      check_val("arst_B", {8'h00, Bval}, 16'h0000);
      check_val("arst_X", {15'h0000, X}, 16'h0000);
      check_val("arst_M", {15'h0000, M}, 16'h0000);
      #1;
      Reset = 1'b0;

      // Clear A/X, load B.
      SW = 8'h07; ClearA = 1'b1; LoadB = 1'b1; ClearX = 1'b1;
      tick();
      check_val("clr_A", {8'h00, Aval}, 16'h0000);
      check_val("ldB_B", {8'h00, Bval}, 16'h0007);
      check_val("clr_X", {15'h0000, X}, 16'h0000);
      check_val("ldB_M", {15'h0000, M}, 16'h0001);

      // Subtract then add.
      SW = 8'h03; Sub_Add = 1'b1; LoadA = 1'b1; LoadX = 1'b1;
      tick();
      check_val("sub_A", {8'h00, Aval}, 16'h00FD);
      check_val("sub_X", {15'h0000, X}, 16'h0001);
      SW = 8'h05; LoadA = 1'b1; LoadX = 1'b1;
      tick();
      check_val("add_A", {8'h00, Aval}, 16'h0002);
      check_val("add_X", {15'h0000, X}, 16'h0000);

      // Rebuild A=0xFD, X=1 (B still 0x07) and shift all three.
      ClearA = 1'b1; ClearX = 1'b1;
      tick();
      SW = 8'h03; Sub_Add = 1'b1; LoadA = 1'b1; LoadX = 1'b1;
      tick();
      ShiftA = 1'b1; ShiftB = 1'b1; ShiftX = 1'b1;
      tick();
      check_val("shf_A", {8'h00, Aval}, 16'h00FE);
      check_val("shf_X", {15'h0000, X}, 16'h0001);
      check_val("shf_B", {8'h00, Bval}, 16'h0083);

      // Full multiply sequences.
      run_mult(8'hFE, 8'h03, 16'hFFFA, "mul_m2x3");
      run_mult(8'h80, 8'h80, 16'h4000, "mul_m128sq");
      run_mult(8'h7F, 8'h7F, 16'h3F01, "mul_127sq");
      run_mult(8'hFB, 8'h05, 16'hFFE7, "mul_m5x5");

      // Priority: ClearA beats LoadA (A is nonzero after the last multiply).
      SW = 8'h11; ClearA = 1'b1; LoadA = 1'b1;
      tick();
      check_val("pri_clrA", {8'h00, Aval}, 16'h0000);
      // Priority: LoadA beats ShiftA (A=0 so sum is SW).
      SW = 8'h11; LoadA = 1'b1; ShiftA = 1'b1; ClearX = 1'b1;
      tick();
      check_val("pri_ldA", {8'h00, Aval}, 16'h0011);
      // Priority: LoadB beats ShiftB.
      SW = 8'hAA; LoadB = 1'b1; ShiftB = 1'b1;
      tick();
      check_val("pri_ldB", {8'h00, Bval}, 16'h00AA);

      // Idle: nothing changes over 10 cycles.
      SW = 8'h55;
      for (int i = 0; i < 10; i++) tick();
      check_val("hold_A", {8'h00, Aval}, 16'h0011);
      check_val("hold_B", {8'h00, Bval}, 16'h00AA);
      check_val("hold_X", {15'h0000, X}, 16'h0000);
      check_val("hold_M", {15'h0000, M}, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule : tb_multiplier_datapath

// File: doc/multiplier_datapath.md
Name: multiplier_datapath

Overview:
Register/arithmetic datapath for the 8-bit signed add-shift multiplier. It sits directly downstream of the multiplier control FSM and consumes its Clear/Load/Shift strobes and Sub_Add select. It holds accumulator A, multiplier B and sign-extension bit X, computes the 9-bit add/subtract of A with the switch operand S, and returns M (B[0]) to the FSM. {A,B} forms the 16-bit signed product after the 8-step sequence.

Parameters:
W, 8, operand width; the adder is W+1 bits wide.

Ports:
Clk  in  1  system clock, rising-edge.
Reset  in  1  asynchronous, active-high; clears all state immediately.
SW  in  W  switch operand; multiplier source for LoadB and multiplicand S for the adder.
ClearA / LoadA / ShiftA  in  1 each  A register strobes.
ClearB / LoadB / ShiftB  in  1 each  B register strobes.
ClearX / LoadX / ShiftX  in  1 each  X bit strobes.
Sub_Add  in  1  1 = A - S, 0 = A + S.
Aval  out  W  current A.
Bval  out  W  current B.
X  out  1  current X.
M  out  1  B[0], combinational from the register; feeds the FSM.

Behaviour:
- Reset asserted: A=0, B=0, X=0 (so M=0) with no clock edge required. Registers hold 0 while Reset is high; normal updates resume on the first Clk edge after deassertion.
- Adder (combinational): sum[W:0] = {A[W-1],A} + ({SW[W-1],SW} XOR {W+1{Sub_Add}}) + Sub_Add. Wrap-around is modulo 2^(W+1), with no overflow flag.
- All registers update on the Clk rising edge from pre-edge values, so simultaneous updates never see each other's new values.
- A priority: ClearA > LoadA > ShiftA > hold. Actions: clear gives 0; load gives sum[W-1:0]; shift gives {X, A[W-1:1]}, an arithmetic right shift with X as the fill bit.
- X priority: ClearX > LoadX > ShiftX > hold. Actions: clear gives 0; load gives sum[W]; shift holds X, which preserves the sign.
- B priority: ClearB > LoadB > ShiftB > hold. Actions: clear gives 0; load gives SW; shift gives {A[0], B[W-1:1]} using the pre-edge A[0].
- Same-cycle LoadA and ShiftB: B[W-1] receives the old A[0], not sum[0]. The FSM sequence relies on this.
- Latency: one Clk edge from strobe to register update. Aval, Bval, X and M are registered values, valid the cycle after the edge.
- No strobe asserted: all state holds indefinitely.
- Reset mid-multiply: partial product is discarded; A=B=X=0. The FSM is reset by the same signal.

Decomposition:
- Shared package mult_pkg: constant DATA_W=8.
- One sub-module, add_sub_9: combinational (W+1)-bit ripple adder with invert/carry-in on Sub_Add. It is instantiated once.
- Registers stay in multiplier_datapath as always_ff blocks with asynchronous reset.

Test Plan:
1. Pulse Reset between clock edges with A=0x5A, B=0x33, X=1 -> A=0x00, B=0x00, X=0, M=0 before the next Clk edge.
2. SW=0x07; ClearA=LoadB=ClearX=1 for one edge -> A=0x00, B=0x07, X=0, M=1.
3. A=0x00, SW=0x03, Sub_Add=1, LoadA=LoadX=1 -> A=0xFD, X=1. Then Sub_Add=0, SW=0x05, LoadA=LoadX=1 -> A=0x02, X=0.
4. A=0xFD, X=1, B=0x07; ShiftA=ShiftB=ShiftX=1 -> A=0xFE, X=1, B=0x83.
5. Scripted FSM sequence with B=0x03 and SW=0xFE (-2): for steps 1-7, add if M then shift; step 8 subtracts if M then shifts. Result {A,B}=0xFFFA (-6). Repeat with SW=0x80, B=0x80 -> 0x4000; and SW=0x7F, B=0x7F -> 0x3F01.
6. Priority checks:
   - ClearA and LoadA same edge -> A=0x00.
   - LoadA and ShiftA same edge -> A=sum[7:0].
   - LoadB and ShiftB with SW=0xAA -> B=0xAA.
   - No strobes for 10 cycles -> all values unchanged.
